// File: rtl/dsp_pkg.sv
// Constants shared by the DSP48A1 wrapper and its result collector.
package dsp_pkg;

  localparam int DSP_P_WIDTH      = 48;
  localparam int DSP_MAX_LATENCY  = 8;
  // Operand-to-P latency of the DSP top; the collector's LATENCY defaults to it.
  localparam int DSP_PIPE_LATENCY = 4;
  localparam int COLLECTOR_DEPTH  = 8;

endpackage

// File: rtl/dsp_result_collector_if.sv
// Issue, DSP P-result and result-stream signals of the collector.
interface dsp_result_collector_if
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DSP_P_WIDTH,
  parameter int DEPTH      = COLLECTOR_DEPTH
) ();

  logic                         issue_valid;
  logic                         issue_ready;
  logic [DATA_WIDTH-1:0]        p_in;
  logic                         res_valid;
  logic                         res_ready;
  logic [DATA_WIDTH-1:0]        res_data;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic                         overflow_err;

  // Collector side.
  modport slave (
    input  issue_valid, p_in, res_ready,
    output issue_ready, res_valid, res_data, occupancy, overflow_err
  );

  // Upstream issuer / downstream consumer side.
  modport master (
    output issue_valid, p_in, res_ready,
    input  issue_ready, res_valid, res_data, occupancy, overflow_err
  );

endinterface

// File: rtl/result_fifo.sv
// Circular result buffer with stored count and sticky overflow flag.
module result_fifo #(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int SW        = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [SW-1:0]         stored,
  output logic                  overflow_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [SW-1:0]         stored_reg;
  logic                  overflow_reg;
  logic                  empty;
  logic                  full;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (stored_reg == '0);
  assign full    = (stored_reg == SW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      stored_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      stored_reg <= stored_reg + SW'(push_ok) - SW'(pop_ok);
      if (push & ~push_ok) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign rd_data      = empty ? '0 : mem[rd_ptr_reg];
  assign stored       = stored_reg;
  assign overflow_err = overflow_reg;

endmodule

// File: rtl/dsp_result_collector.sv
// Tags issues through the fixed DSP latency, buffers each P result, and
// limits issue by credits so every in-flight result always has a slot.
module dsp_result_collector
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DSP_P_WIDTH,
  parameter int LATENCY    = DSP_PIPE_LATENCY,
  parameter int DEPTH      = COLLECTOR_DEPTH
) (
  input logic                   clk,
  input logic                   rst_n,
  dsp_result_collector_if.slave bus
);

  localparam int CW = $clog2(DEPTH+1);

  logic [LATENCY-1:0] vsh_reg;
  logic [LATENCY-1:0] vsh_next;
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      cnt_next;
  logic [CW-1:0]      stored;
  logic               issue_fire;
  logic               pop;
  logic               push;

  assign issue_fire = bus.issue_valid & bus.issue_ready;
  assign pop        = bus.res_valid & bus.res_ready;
  assign push       = vsh_reg[LATENCY-1];

  assign vsh_next[0] = issue_fire;
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vsh
    assign vsh_next[gi] = vsh_reg[gi-1];
  end

  assign cnt_next = cnt_reg + CW'(issue_fire) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsh_reg <= '0;
      cnt_reg <= '0;
    end else begin
      vsh_reg <= vsh_next;
      cnt_reg <= cnt_next;
    end
  end

  // Registered credit count only: no path from res_ready to issue_ready.
  assign bus.issue_ready = (cnt_reg < CW'(DEPTH));
  assign bus.occupancy   = cnt_reg;
  assign bus.res_valid   = (stored != '0);

  result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_data    (bus.p_in),
    .pop          (pop),
    .rd_data      (bus.res_data),
    .stored       (stored),
    .overflow_err (bus.overflow_err)
  );

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed and streaming bench for dsp_result_collector with a DSP pipe model.
module tb_dsp_result_collector;
  import dsp_pkg::*;

  localparam int DW    = DSP_P_WIDTH;
  localparam int LAT   = DSP_PIPE_LATENCY;
  localparam int DEPTH = COLLECTOR_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_result_collector_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  dsp_result_collector #(
    .DATA_WIDTH (DW),
    .LATENCY    (LAT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] data_pipe [LAT];
  bit            tag_pipe  [LAT];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] next_data;
  bit            model_ovf;
  bit            relax;
  int            n_vec;
  int            n_err;
  int            fires;
  int            pops;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int inflight();
    int n = 0;
    for (int i = 0; i < LAT; i++) n += int'(tag_pipe[i]);
    return n;
  endfunction

  // One clock: check outputs at negedge, advance the model at posedge, drive p_in after.
  task automatic step();
    bit            fire;
    bit            pop;
    bit            push;
    bit            was_full;
    int            exp_cnt;
    logic [DW-1:0] pdata;
    @(negedge clk);
    exp_cnt = exp_q.size() + inflight();
    if (!relax) begin
      chk("occupancy", 64'(bus.occupancy), 64'(exp_cnt));
      chk("issue_ready", 64'(bus.issue_ready), 64'(exp_cnt < DEPTH));
    end
    chk("res_valid", 64'(bus.res_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("res_data", 64'(bus.res_data), 64'(exp_q[0]));
    chk("overflow_err", 64'(bus.overflow_err), 64'(model_ovf));
    fire = rst_n && bus.issue_valid && bus.issue_ready;
    pop  = rst_n && bus.res_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (rst_n) begin
      push     = tag_pipe[LAT-1];
      pdata    = data_pipe[LAT-1];
      was_full = (exp_q.size() == DEPTH);
      if (pop) begin
        $display("pop   data=%h", exp_q[0]);
        void'(exp_q.pop_front());
        pops++;
      end
      if (push) begin
        if (was_full && !pop) model_ovf = 1'b1;
        else exp_q.push_back(pdata);
      end
    end
    for (int i = LAT-1; i > 0; i--) begin
      tag_pipe[i]  = tag_pipe[i-1];
      data_pipe[i] = data_pipe[i-1];
    end
    tag_pipe[0]  = fire;
    data_pipe[0] = next_data;
    if (fire) begin
      $display("issue data=%h", next_data);
      fires++;
      next_data++;
    end
    #1 bus.p_in = data_pipe[LAT-1];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; fires = 0; pops = 0;
    model_ovf = 1'b0; relax = 1'b0; next_data = '0;
    for (int i = 0; i < LAT; i++) begin
      tag_pipe[i]  = 1'b0;
      data_pipe[i] = '0;
    end
    bus.issue_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.p_in        = '0;

    // Reset values
    step();
    step();
    rst_n = 1'b1;

    // Single issue, result visible exactly one cycle with res_ready=1
    next_data = 48'h0000_0000_00AB;
    bus.res_ready   = 1'b1;
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    repeat (LAT + 3) step();
    chk("t1_pops", 64'(pops), 64'd1);
    chk("t1_occupancy", 64'(bus.occupancy), 64'd0);

    // Fill with res_ready=0
    bus.res_ready   = 1'b0;
    next_data       = '0;
    fires           = 0;
    bus.issue_valid = 1'b1;
    repeat (DEPTH + LAT) step();
    chk("t2_fires", 64'(fires), 64'(DEPTH));
    chk("t2_issue_ready", 64'(bus.issue_ready), 64'd0);
    chk("t2_occupancy", 64'(bus.occupancy), 64'(DEPTH));
    chk("t2_head", 64'(bus.res_data), 64'd0);

    // Single pop frees one credit; one more issue refills
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("t3_ready_after_pop", 64'(bus.issue_ready), 64'd1);
    step();
    chk("t3_ready_refull", 64'(bus.issue_ready), 64'd0);
    bus.issue_valid = 1'b0;
    repeat (LAT + 1) step();
    chk("t3_head", 64'(bus.res_data), 64'd1);
    bus.res_ready = 1'b1;
    repeat (DEPTH + 1) step();
    chk("t3_drained", 64'(bus.res_valid), 64'd0);
    chk("t3_last", 64'(next_data), 64'd9);

    // Streaming with random backpressure
    next_data = '0;
    fires     = 0;
    for (int c = 0; c < 20000 && fires < 1000; c++) begin
      bus.issue_valid = 1'b1;
      bus.res_ready   = 1'($urandom_range(0, 1));
      step();
    end
    bus.issue_valid = 1'b0;
    chk("t4_fires", 64'(fires), 64'd1000);
    bus.res_ready = 1'b1;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || inflight() != 0); c++) step();
    step();
    chk("t4_empty", 64'(bus.res_valid), 64'd0);
    chk("t4_occupancy", 64'(bus.occupancy), 64'd0);

    // Reset with three results in flight
    bus.res_ready   = 1'b0;
    next_data       = 48'h5000;
    bus.issue_valid = 1'b1;
    repeat (3) step();
    bus.issue_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < LAT; i++) tag_pipe[i] = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("t5_rst_ready", 64'(bus.issue_ready), 64'd1);
    chk("t5_rst_valid", 64'(bus.res_valid), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (LAT + 2) step();
    chk("t5_no_push", 64'(bus.res_valid), 64'd0);

    // Forced overflow past the credit check
    next_data       = 48'h600;
    bus.issue_valid = 1'b1;
    repeat (DEPTH + LAT + 1) step();
    bus.issue_valid = 1'b0;
    chk("t6_full", 64'(bus.occupancy), 64'(DEPTH));
    relax = 1'b1;
    force bus.issue_ready = 1'b1;
    next_data       = 48'hDEAD;
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    repeat (LAT + 1) step();
    chk("t6_overflow", 64'(bus.overflow_err), 64'd1);
    release bus.issue_ready;
    chk("t6_head", 64'(bus.res_data), 64'h600);
    bus.res_ready = 1'b1;
    repeat (DEPTH + 1) step();
    chk("t6_sticky", 64'(bus.overflow_err), 64'd1);
    chk("t6_drained", 64'(bus.res_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
